// File: rtl/pulp_clock_gate_ctrl.sv
// Per-domain clock-enable scheduler. Each gated domain has its own
// OFF/WAKE/ON/IDLE state machine: a fixed wake-up delay before a grant, and
// a programmable idle timeout before the clock is removed.
module pulp_clock_gate_ctrl #(
    parameter int unsigned NUM_DOMAINS = 4,
    parameter int unsigned IDLE_CNT_W  = 8,
    parameter int unsigned WAKE_CYCLES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   test_mode_i,
    input  logic [NUM_DOMAINS-1:0] req_i,
    input  logic [NUM_DOMAINS-1:0] busy_i,
    input  logic [NUM_DOMAINS-1:0] force_on_i,
    input  logic [NUM_DOMAINS-1:0] force_off_i,
    input  logic [IDLE_CNT_W-1:0]  idle_thresh_i,
    output logic [NUM_DOMAINS-1:0] clk_en_o,
    output logic [NUM_DOMAINS-1:0] ack_o,
    output logic                   any_active_o
);

    // One counter serves both the wake delay (up to 14) and the idle timeout.
    localparam int unsigned CntW = (IDLE_CNT_W > 4) ? IDLE_CNT_W : 4;
    localparam logic [CntW-1:0] WakeLoad = CntW'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        StOff,
        StWake,
        StOn,
        StIdle
    } state_e;

    state_e          state_q [NUM_DOMAINS];
    state_e          state_d [NUM_DOMAINS];
    logic [CntW-1:0] cnt_q   [NUM_DOMAINS];
    logic [CntW-1:0] cnt_d   [NUM_DOMAINS];

    logic [NUM_DOMAINS-1:0] want;
    logic [NUM_DOMAINS-1:0] act;
    logic [NUM_DOMAINS-1:0] kill;

    assign want = (req_i | force_on_i) & ~force_off_i;
    assign act  = req_i | busy_i | force_on_i;
    // A busy domain is never gated, even when software asks for it.
    assign kill = force_off_i & ~busy_i;

    // Next-state and counter update for every domain.
    always_comb begin
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                StOff: begin
                    if (want[i]) begin
                        state_d[i] = StWake;
                        cnt_d[i]   = WakeLoad;
                    end
                end
                StWake: begin
                    if (kill[i]) begin
                        state_d[i] = StOff;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == '0) begin
                        state_d[i] = StOn;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CntW'(1);
                    end
                end
                StOn: begin
                    if (kill[i]) begin
                        state_d[i] = StOff;
                        cnt_d[i]   = '0;
                    end else if (!act[i]) begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = CntW'(idle_thresh_i);
                    end
                end
                StIdle: begin
                    // Activity wins over an expiring timeout.
                    if (act[i] && !force_off_i[i]) begin
                        state_d[i] = StOn;
                        cnt_d[i]   = '0;
                    end else if (kill[i]) begin
                        state_d[i] = StOff;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == '0) begin
                        if (!busy_i[i]) begin
                            state_d[i] = StOff;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] - CntW'(1);
                    end
                end
                default: begin
                    state_d[i] = StOff;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // State and counter registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                state_q[i] <= StOff;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Outputs depend only on registered state plus direct inputs.
    always_comb begin
        clk_en_o = '0;
        ack_o    = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            clk_en_o[i] = (state_q[i] != StOff) | test_mode_i;
            ack_o[i]    = (state_q[i] == StOn) & req_i[i] & ~force_off_i[i];
        end
        any_active_o = |clk_en_o;
    end

endmodule

// File: tb/tb_pulp_clock_gate_ctrl.sv
// Scoreboard bench for pulp_clock_gate_ctrl: each stimulus step queues the
// outputs it expects at a given future cycle; a negedge monitor compares them.
module tb_pulp_clock_gate_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       test_mode_i;
    logic [3:0] req_i;
    logic [3:0] busy_i;
    logic [3:0] force_on_i;
    logic [3:0] force_off_i;
    logic [7:0] idle_thresh_i;
    logic [3:0] clk_en_o;
    logic [3:0] ack_o;
    logic       any_active_o;

    pulp_clock_gate_ctrl #(
        .NUM_DOMAINS(4),
        .IDLE_CNT_W (8),
        .WAKE_CYCLES(2)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .test_mode_i  (test_mode_i),
        .req_i        (req_i),
        .busy_i       (busy_i),
        .force_on_i   (force_on_i),
        .force_off_i  (force_off_i),
        .idle_thresh_i(idle_thresh_i),
        .clk_en_o     (clk_en_o),
        .ack_o        (ack_o),
        .any_active_o (any_active_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        int    cyc;
        string tag;
        int    sig;  // 0: clk_en_o, 1: ack_o, 2: any_active_o
        int    idx;
        logic  val;
    } sb_item_t;

    sb_item_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic sample(input int sig, input int idx);
        case (sig)
            0:       return clk_en_o[idx];
            1:       return ack_o[idx];
            default: return any_active_o;
        endcase
    endfunction

    // Queue expected value val for signal sig[idx] after edges cyc+from..cyc+to.
    task automatic expect_span(input string tag, input int sig, input int idx,
                               input int from, input int to, input logic val);
        for (int d = from; d <= to; d++) begin
            sb_item_t it;
            it.cyc = cyc + d;
            it.tag = $sformatf("%s@+%0d", tag, d);
            it.sig = sig;
            it.idx = idx;
            it.val = val;
            sb_q.push_back(it);
        end
    endtask

    // Monitor: compare every queued item due at this cycle.
    always @(negedge clk_i) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == cyc) begin
                check(sb_q[i].tag, 32'(sample(sb_q[i].sig, sb_q[i].idx)), 32'(sb_q[i].val));
                sb_q.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
        #1;
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_en"}, 32'(clk_en_o), 32'h0);
        check({tag, "_ack"}, 32'(ack_o), 32'h0);
        check({tag, "_any"}, 32'(any_active_o), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_ni        = 1'b0;
        test_mode_i   = 1'b0;
        req_i         = '0;
        busy_i        = '0;
        force_on_i    = '0;
        force_off_i   = '0;
        idle_thresh_i = 8'd5;

        // Reset state, then test-mode override during reset.
        #3;
        check_all_low("rst");
        test_mode_i = 1'b1;
        #1;
        check("rst_tm_en", 32'(clk_en_o), 32'hf);
        check("rst_tm_any", 32'(any_active_o), 32'h1);
        test_mode_i = 1'b0;
        @(negedge clk_i);
        #1;
        rst_ni = 1'b1;
        tick(1);

        // Wake latency on domain 0; others stay off.
        req_i[0] = 1'b1;
        expect_span("s1_en0", 0, 0, 1, 3, 1'b1);
        expect_span("s1_ack0", 1, 0, 1, 2, 1'b0);
        expect_span("s1_ack0", 1, 0, 3, 3, 1'b1);
        for (int d = 1; d < 4; d++) expect_span($sformatf("s1_en%0d", d), 0, d, 1, 3, 1'b0);
        expect_span("s1_any", 2, 0, 1, 1, 1'b1);
        tick(3);

        // Idle timeout of 5: ack drops at once, clock off 7 edges later.
        req_i[0] = 1'b0;
        #1;
        check("s2_ack_drop", 32'(ack_o[0]), 32'h0);
        expect_span("s2_en0", 0, 0, 1, 6, 1'b1);
        expect_span("s2_en0", 0, 0, 7, 7, 1'b0);
        tick(8);

        // Idle timeout of 0: one extra cycle of clock.
        idle_thresh_i = 8'd0;
        req_i[0] = 1'b1;
        expect_span("s2b_ack0", 1, 0, 3, 3, 1'b1);
        tick(3);
        req_i[0] = 1'b0;
        expect_span("s2b_en0", 0, 0, 1, 1, 1'b1);
        expect_span("s2b_en0", 0, 0, 2, 2, 1'b0);
        tick(3);

        // Busy pulse in IDLE with 2 counts left restarts the full timeout.
        idle_thresh_i = 8'd5;
        req_i[1] = 1'b1;
        expect_span("s3_ack1", 1, 1, 3, 3, 1'b1);
        tick(3);
        req_i[1] = 1'b0;
        expect_span("s3_en1", 0, 1, 1, 11, 1'b1);
        expect_span("s3_en1", 0, 1, 12, 12, 1'b0);
        expect_span("s3_ack1", 1, 1, 5, 5, 1'b0);
        tick(4);
        busy_i[1] = 1'b1;
        tick(1);
        busy_i[1] = 1'b0;
        tick(9);

        // force_off held off by busy, honoured one cycle after busy falls.
        req_i[2]  = 1'b1;
        busy_i[2] = 1'b1;
        expect_span("s4_ack2", 1, 2, 3, 3, 1'b1);
        tick(3);
        force_off_i[2] = 1'b1;
        #1;
        check("s4_ack_fo", 32'(ack_o[2]), 32'h0);
        expect_span("s4_en2_busy", 0, 2, 1, 4, 1'b1);
        tick(4);
        busy_i[2] = 1'b0;
        req_i[2]  = 1'b0;
        expect_span("s4_en2_off", 0, 2, 1, 1, 1'b0);
        tick(2);
        // force_off beats both req and force_on.
        req_i[2]      = 1'b1;
        force_on_i[2] = 1'b1;
        expect_span("s4_en2_stay", 0, 2, 1, 3, 1'b0);
        expect_span("s4_ack2_stay", 1, 2, 1, 3, 1'b0);
        tick(3);
        req_i[2]       = 1'b0;
        force_on_i[2]  = 1'b0;
        force_off_i[2] = 1'b0;
        tick(1);

        // Asynchronous reset mid-WAKE.
        req_i[3] = 1'b1;
        tick(1);
        check("s5_wake_en", 32'(clk_en_o[3]), 32'h1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_all_low("s5_rst_wake");
        test_mode_i = 1'b1;
        #1;
        check("s5_rst_tm_en", 32'(clk_en_o), 32'hf);
        test_mode_i = 1'b0;
        req_i[3] = 1'b0;
        @(negedge clk_i);
        #1;
        rst_ni = 1'b1;
        tick(1);
        check("s5_post_rst_en", 32'(clk_en_o), 32'h0);

        // Asynchronous reset in IDLE.
        req_i[0] = 1'b1;
        tick(3);
        req_i[0] = 1'b0;
        tick(2);
        check("s5_idle_en", 32'(clk_en_o[0]), 32'h1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_all_low("s5_rst_idle");
        @(negedge clk_i);
        #1;
        rst_ni = 1'b1;
        tick(1);

        // All four domains at once, then independent gating.
        idle_thresh_i = 8'd0;
        req_i = 4'hf;
        for (int d = 0; d < 4; d++) begin
            expect_span($sformatf("s6_ack%0d", d), 1, d, 2, 2, 1'b0);
            expect_span($sformatf("s6_ack%0d", d), 1, d, 3, 3, 1'b1);
        end
        tick(3);
        busy_i[1] = 1'b1;
        req_i[0]  = 1'b0;
        req_i[1]  = 1'b0;
        expect_span("s6_en0", 0, 0, 1, 1, 1'b1);
        expect_span("s6_en0", 0, 0, 2, 2, 1'b0);
        expect_span("s6_ack0", 1, 0, 1, 1, 1'b0);
        expect_span("s6_en1", 0, 1, 1, 4, 1'b1);
        expect_span("s6_ack1", 1, 1, 1, 1, 1'b0);
        expect_span("s6_ack2", 1, 2, 1, 4, 1'b1);
        expect_span("s6_ack3", 1, 3, 1, 4, 1'b1);
        tick(4);
        busy_i = '0;
        req_i  = '0;
        for (int d = 0; d < 4; d++) expect_span($sformatf("s6_end_en%0d", d), 0, d, 3, 3, 1'b0);
        expect_span("s6_end_any", 2, 0, 3, 3, 1'b0);
        tick(4);

        // Test mode outside reset forces every enable without granting.
        test_mode_i = 1'b1;
        #1;
        check("s7_tm_en", 32'(clk_en_o), 32'hf);
        check("s7_tm_any", 32'(any_active_o), 32'h1);
        check("s7_tm_ack", 32'(ack_o), 32'h0);
        test_mode_i = 1'b0;
        #1;
        check("s7_tm_off", 32'(clk_en_o), 32'h0);

        check("sb_leftover", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pulp_clock_gate_ctrl.md
# pulp_clock_gate_ctrl

Per-domain clock-enable scheduler for the SoC's gated clock domains. It turns requester request/busy activity plus software force controls into the enable inputs of the `pulp_clock_gating` cells. Each domain runs its own wake/idle state machine, with a fixed wake-up delay and a programmable idle timeout before the clock is removed. It sits in the clock/reset generation area beside the clock cells and runs on the ungated system clock.

## Interface
Parameters:
- NUM_DOMAINS, 4: number of independently gated clock domains.
- IDLE_CNT_W, 8: width of the idle-timeout counter and threshold.
- WAKE_CYCLES, 2: cycles of enabled clock before a grant is given; legal range 1..15.

Ports:
- clk_i  in  1  ungated system clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- test_mode_i  in  1  DFT override: forces every clk_en_o high; FSMs keep running.
- req_i  in  NUM_DOMAINS  per-domain clock request from the requester.
- busy_i  in  NUM_DOMAINS  per-domain activity from inside the gated domain; blocks gating.
- force_on_i  in  NUM_DOMAINS  software keep-alive, from an APB config register.
- force_off_i  in  NUM_DOMAINS  software shutdown request, from an APB config register.
- idle_thresh_i  in  IDLE_CNT_W  idle cycles tolerated before gating; shared by all domains; quasi-static.
- clk_en_o  out  NUM_DOMAINS  enable to the domain's clock-gating cell.
- ack_o  out  NUM_DOMAINS  grant: the domain's clock is stable and usable.
- any_active_o  out  1  OR of all clk_en_o, for the power-management unit.

## Operation
- Each domain has its own independent FSM and counter. Both are held in registers only, with no state shared between domains.
- States:
  - OFF: clock off.
  - WAKE: clock on, waiting for the wake-up delay.
  - ON: clock on, grant possible.
  - IDLE: clock on, counting down to gating.
- Definitions: want = (req_i | force_on_i) & ~force_off_i; act = req_i | busy_i | force_on_i.
- Transitions:
  - OFF -> WAKE when want. Wake counter loads WAKE_CYCLES-1.
  - WAKE -> ON when the wake counter is 0; otherwise decrement. force_off_i in WAKE, with busy_i low, -> OFF.
  - ON -> OFF when force_off_i & ~busy_i. force_off_i takes priority over force_on_i.
  - ON -> IDLE when ~act. Idle counter loads idle_thresh_i.
  - IDLE -> ON when act & ~force_off_i.
  - IDLE -> OFF when the idle counter is 0, or when force_off_i & ~busy_i. Otherwise decrement.
- Outputs:
  - clk_en_o[i] = (state != OFF) | test_mode_i.
  - ack_o[i] = (state == ON) & req_i[i] & ~force_off_i[i].
  - any_active_o = |clk_en_o.
- Handshake: the requester raises req_i and holds it until ack_o. It keeps req_i high for as long as it uses the domain. Dropping req_i ends the grant, and ack_o drops in the same cycle.
- If busy_i is high, the domain is never gated, including under force_off_i. force_off_i is honoured once busy_i falls.
- If req_i drops in WAKE, the FSM still completes WAKE to ON, then goes to IDLE.
- Reset, asynchronous, at any time including mid-wake or mid-idle:
  - all FSMs go to OFF and all counters to 0;
  - clk_en_o = test_mode_i replicated, ack_o = 0, any_active_o = test_mode_i.
- Counters saturate at 0 and never wrap.

## Timing
- req_i is sampled high at edge 0 with the domain in OFF:
  - clk_en_o is high after edge 1;
  - ack_o is high after edge 1+WAKE_CYCLES (edge 3 at the default).
- req_i is already high in ON: ack_o is combinational, with zero latency.
- act falls in the cycle before edge k, with the domain in ON:
  - IDLE is entered at edge k;
  - OFF is entered at edge k+1+idle_thresh_i;
  - with idle_thresh_i = 0, the clock stays on for exactly 1 extra cycle.
- force_off_i asserted before edge k with busy_i low: clk_en_o is low after edge k, a 1-cycle latency.
- Simultaneous events: req_i and force_off_i together means the domain is not woken (force_off_i wins). act arriving in the same cycle the idle counter reaches 0 returns the domain to ON and does not gate it.
- All outputs are glitch-free relative to clk_i. clk_en_o and ack_o derive only from registered state plus the listed inputs.

## Test plan
- Reset with test_mode_i=0, then req_i[0]=1 at cycle 0, defaults: clk_en_o[0] rises at cycle 1, ack_o[0] rises at cycle 3, other domains stay at 0.
- idle_thresh_i=5, drop req_i[0] in ON, busy_i=0: IDLE at +1, clk_en_o[0] low at +7. Repeat with idle_thresh_i=0: clk_en_o low at +2.
- In IDLE with 2 counts left, pulse busy_i[1]: domain returns to ON, no gating. Then busy_i low: the full timeout restarts.
- force_off_i[2]=1 while busy_i[2]=1 in ON: clk_en_o stays 1. busy_i falls: clk_en_o falls 1 cycle later. force_on_i together with force_off_i: domain stays OFF.
- Assert rst_ni low mid-WAKE and in IDLE: clk_en_o, ack_o and any_active_o drop immediately (asynchronously) to 0. test_mode_i=1 during reset: clk_en_o = all-ones.
- All 4 domains request in the same cycle: all get ack_o 3 cycles later, each gates independently per its own req_i/busy_i.
